bp_wb_mem_arbiter: RTL and testbench

BP_WB_MEM_ARBITER -- requirements
Module: bp_wb_mem_arbiter

---
 rtl/bp_wb_mem_arbiter_if.sv | 50 +++++
 rtl/bp_wb_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_bp_wb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_wb_mem_arbiter_if.sv
// Bundles the two-requester command/response channels and the Wishbone master bus
// of bp_wb_mem_arbiter; master = arbiter side, slave = requesters plus Wishbone target.
interface bp_wb_mem_arbiter_if #(
  parameter int addr_width_p = 37,
  parameter int data_width_p = 64
);
  localparam int sel_width_lp = data_width_p / 8;

  logic [1:0]                        req_v_i;
  logic [1:0]                        req_ready_o;
  logic [1:0][addr_width_p-1:0]      req_addr_i;
  logic [1:0][data_width_p-1:0]      req_data_i;
  logic [1:0][sel_width_lp-1:0]      req_sel_i;
  logic [1:0]                        req_we_i;

  logic [1:0]                        resp_v_o;
  logic [1:0]                        resp_ready_i;
  logic [data_width_p-1:0]           resp_data_o;
  logic                              resp_err_o;

  logic [addr_width_p-1:0]           wb_adr_o;
  logic [data_width_p-1:0]           wb_dat_o;
  logic [data_width_p-1:0]           wb_dat_i;
  logic [sel_width_lp-1:0]           wb_sel_o;
  logic                              wb_we_o;
  logic                              wb_stb_o;
  logic                              wb_cyc_o;
  logic                              wb_ack_i;
  logic                              wb_err_i;
  logic [2:0]                        wb_cti_o;
  logic [1:0]                        wb_bte_o;

  logic                              busy_o;

  modport master (
    input  req_v_i, req_addr_i, req_data_i, req_sel_i, req_we_i, resp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_cti_o, wb_bte_o,
           busy_o
  );

  modport slave (
    output req_v_i, req_addr_i, req_data_i, req_sel_i, req_we_i, resp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_cti_o, wb_bte_o,
           busy_o
  );
endinterface

// File: rtl/bp_wb_mem_arbiter.sv
// Round-robin arbiter of two requesters onto one classic Wishbone master, one transaction at a time.
// cyc rises 1 cycle after the command handshake; the response is held until the granted requester accepts it.
module bp_wb_mem_arbiter #(
  parameter int addr_width_p = 37,
  parameter int data_width_p = 64,
  parameter int timeout_p    = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  bp_wb_mem_arbiter_if.master  bus
);
  localparam int sel_width_lp = data_width_p / 8;
  localparam int cnt_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(timeout_p - 1);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_bus  = 2'd1,
    e_resp = 2'd2
  } state_e;

  state_e                   r_state;
  state_e                   w_state_n;
  logic                     r_last_grant;
  logic                     r_grant;
  logic [cnt_width_lp-1:0]  r_cnt;
  logic [addr_width_p-1:0]  r_adr;
  logic [data_width_p-1:0]  r_dat;
  logic [sel_width_lp-1:0]  r_sel;
  logic                     r_we;
  logic [data_width_p-1:0]  r_resp_data;
  logic                     r_resp_err;

  logic                     w_grant;
  logic                     w_req_hs;
  logic                     w_resp_hs;
  logic                     w_bus_done;
  logic [1:0]               w_req_ready;
  logic [1:0]               w_resp_v;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_grant = bus.req_v_i[1];
    if (bus.req_v_i == 2'b11) begin
      w_grant = ~r_last_grant;
    end
  end

  always_comb begin
    w_req_ready = 2'b00;
    if (reset_n_i && (r_state == e_idle)) begin
      w_req_ready[w_grant] = bus.req_v_i[w_grant];
    end
  end

  always_comb begin
    w_resp_v = 2'b00;
    if (r_state == e_resp) begin
      w_resp_v[r_grant] = 1'b1;
    end
  end

  assign w_req_hs   = |(w_req_ready & bus.req_v_i);
  assign w_resp_hs  = (r_state == e_resp) && bus.resp_ready_i[r_grant];
  assign w_bus_done = (r_state == e_bus) &&
                      (bus.wb_ack_i || bus.wb_err_i || (r_cnt == cnt_max_lp));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= e_idle;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      e_idle:  if (w_req_hs)   w_state_n = e_bus;
      e_bus:   if (w_bus_done) w_state_n = e_resp;
      e_resp:  if (w_resp_hs)  w_state_n = e_idle;
      default: w_state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_we         <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_adr        <= bus.req_addr_i[w_grant];
        r_dat        <= bus.req_data_i[w_grant];
        r_sel        <= bus.req_sel_i[w_grant];
        r_we         <= bus.req_we_i[w_grant];
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        r_cnt        <= '0;
      end
      // err outranks ack; the counter saturates at the abort point instead of wrapping.
      if (r_state == e_bus) begin
        if (bus.wb_err_i) begin
          r_resp_err  <= 1'b1;
          r_resp_data <= '0;
        end else if (bus.wb_ack_i) begin
          r_resp_err  <= 1'b0;
          r_resp_data <= r_we ? '0 : bus.wb_dat_i;
        end else if (r_cnt == cnt_max_lp) begin
          r_resp_err  <= 1'b1;
          r_resp_data <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready_o = w_req_ready;
  assign bus.resp_v_o    = w_resp_v;
  assign bus.resp_data_o = r_resp_data;
  assign bus.resp_err_o  = r_resp_err;
  assign bus.wb_adr_o    = r_adr;
  assign bus.wb_dat_o    = r_dat;
  assign bus.wb_sel_o    = r_sel;
  assign bus.wb_we_o     = r_we;
  assign bus.wb_cyc_o    = (r_state == e_bus);
  assign bus.wb_stb_o    = (r_state == e_bus);
  assign bus.wb_cti_o    = 3'b000;
  assign bus.wb_bte_o    = 2'b00;
  assign bus.busy_o      = (r_state != e_idle);
endmodule

// File: tb/tb_bp_wb_mem_arbiter.sv
// Randomized scoreboard bench for bp_wb_mem_arbiter: requesters, Wishbone target and response sink
// run as separate processes; expectations come from a transaction-level model of the arbitration rules.
module tb_bp_wb_mem_arbiter;
  localparam int AW = 37;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_wb_mem_arbiter_if #(.addr_width_p(AW), .data_width_p(DW)) bus_if ();

  bp_wb_mem_arbiter #(.addr_width_p(AW), .data_width_p(DW), .timeout_p(TO)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus_if)
  );

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent target
  typedef struct { int kind; int lat; logic [DW-1:0] rdata; } plan_t;
  typedef struct { logic idx; logic [DW-1:0] data; logic err; } resp_t;
  typedef struct { logic [AW-1:0] adr; logic [DW-1:0] dat; logic [SW-1:0] sel; logic we; int len; } wbx_t;

  resp_t expq[$];
  wbx_t  wbq[$];
  plan_t slvq[$];

  int checks = 0;
  int errors = 0;

  logic [1:0]    pv = 2'b00;
  logic [AW-1:0] p_adr [2];
  logic [DW-1:0] p_dat [2];
  logic [SW-1:0] p_sel [2];
  logic          p_we  [2];
  plan_t         p_plan[2];
  bit            p_disc[2];
  bit            m_last = 1'b1;
  bit            in_flight = 1'b0;
  bit            hs_pending = 1'b0;
  int            bp_next = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic we, input int kind, input int lat,
                         input logic [DW-1:0] rd, input bit disc);
    pv[i] = 1'b1;
    p_adr[i] = a; p_dat[i] = d; p_sel[i] = s; p_we[i] = we; p_disc[i] = disc;
    p_plan[i].kind = kind; p_plan[i].lat = lat; p_plan[i].rdata = rd;
    bus_if.req_v_i[i]    = 1'b1;
    bus_if.req_addr_i[i] = a;
    bus_if.req_data_i[i] = d;
    bus_if.req_sel_i[i]  = s;
    bus_if.req_we_i[i]   = we;
  endtask

  task automatic rand_req(input int i);
    logic [63:0] t;
    int r;
    int kind;
    t = {$urandom, $urandom};
    r = int'($urandom % 10);
    kind = (r < 6) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : (r == 9) ? 3 : 0;
    set_req(i, t[AW-1:0], {$urandom, $urandom}, SW'($urandom), 1'($urandom),
            kind, int'($urandom % 10), {$urandom, $urandom}, 1'b0);
  endtask

  // Waits for the command handshake, compares the grant with the model, queues expectations.
  task automatic wait_grant(output int g_out);
    int g;
    int exp_g;
    bit ok;
    bit to;
    resp_t r;
    wbx_t w;
    exp_g = (pv == 2'b11) ? int'(!m_last) : int'(pv[1]);
    ok = 1'b0;
    g_out = exp_g;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus_if.req_ready_o != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail("grant_timeout");
      return;
    end
    g = bus_if.req_ready_o[1] ? 1 : 0;
    chk("req_ready_grant", 64'(bus_if.req_ready_o), 64'(1 << exp_g));
    to = (p_plan[g].kind == 3) || (p_plan[g].lat >= TO);
    w.adr = p_adr[g]; w.dat = p_dat[g]; w.sel = p_sel[g]; w.we = p_we[g];
    w.len = p_disc[g] ? -1 : (to ? TO : p_plan[g].lat + 1);
    wbq.push_back(w);
    slvq.push_back(p_plan[g]);
    if (!p_disc[g]) begin
      r.idx  = g[0];
      r.err  = to || (p_plan[g].kind != 0);
      r.data = (r.err || p_we[g]) ? '0 : p_plan[g].rdata;
      expq.push_back(r);
    end
    m_last = g[0];
    @(posedge clk);
    #1;
    in_flight = 1'b1;
    pv[g] = 1'b0;
    bus_if.req_v_i[g] = 1'b0;
    chk("issue_latency_cyc", 64'(bus_if.wb_cyc_o), 64'd1);
    g_out = g;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (expq.size() == 0 && !in_flight && !hs_pending) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  // Wishbone target: answers per plan, sprinkles stray ack/err whenever cyc is low.
  initial begin
    plan_t p;
    int i;
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_err_i = 1'b0;
    bus_if.wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.wb_cyc_o) begin
        if (slvq.size() > 0) p = slvq.pop_front();
        else begin p.kind = 3; p.lat = 0; p.rdata = '0; end
        i = 0;
        while (bus_if.wb_cyc_o && i < 64) begin
          bus_if.wb_ack_i = 1'b0;
          bus_if.wb_err_i = 1'b0;
          bus_if.wb_dat_i = {$urandom, $urandom};
          if (i == p.lat && p.kind != 3) begin
            bus_if.wb_ack_i = (p.kind == 0) || (p.kind == 2);
            bus_if.wb_err_i = (p.kind == 1) || (p.kind == 2);
            if (p.kind == 0) bus_if.wb_dat_i = p.rdata;
          end
          @(posedge clk);
          #1;
          i++;
        end
        bus_if.wb_ack_i = 1'b0;
        bus_if.wb_err_i = 1'b0;
      end else begin
        bus_if.wb_ack_i = ($urandom % 6 == 0);
        bus_if.wb_err_i = ($urandom % 8 == 0);
        bus_if.wb_dat_i = {$urandom, $urandom};
      end
    end
  end

  // Monitor: Wishbone cycle checks, response scoreboard, response backpressure.
  initial begin
    bit prev_cyc;
    int run;
    int elen;
    bit in_resp;
    int w;
    resp_t e;
    wbx_t x;
    logic [1:0] held_v;
    logic [DW-1:0] held_d;
    logic held_e;
    logic [1:0] rb;
    logic [1:0] rr;
    prev_cyc = 1'b0; run = 0; elen = -1; in_resp = 1'b0; w = 0;
    held_v = 2'b00; held_d = '0; held_e = 1'b0;
    bus_if.resp_ready_i = 2'b00;
    forever begin
      @(negedge clk);
      if (hs_pending) begin
        in_flight = 1'b0;
        hs_pending = 1'b0;
      end
      rr = bus_if.req_ready_o;
      chk("req_ready_legal", 64'(($countones(rr) > 1) || (in_flight && rr != 2'b00)), 64'd0);
      chk("busy", 64'(bus_if.busy_o), 64'(in_flight));

      if (bus_if.wb_cyc_o && !prev_cyc) begin
        if (wbq.size() == 0) begin
          fail("unexpected_cyc");
          elen = -1;
        end else begin
          x = wbq.pop_front();
          chk("wb_adr", 64'(bus_if.wb_adr_o), 64'(x.adr));
          chk("wb_dat", bus_if.wb_dat_o, x.dat);
          chk("wb_sel", 64'(bus_if.wb_sel_o), 64'(x.sel));
          chk("wb_we", 64'(bus_if.wb_we_o), 64'(x.we));
          chk("wb_stb", 64'(bus_if.wb_stb_o), 64'd1);
          chk("wb_cti_bte", 64'({bus_if.wb_cti_o, bus_if.wb_bte_o}), 64'd0);
          elen = x.len;
        end
        run = 1;
      end else if (bus_if.wb_cyc_o) begin
        run++;
      end else if (prev_cyc && elen >= 0) begin
        chk("cyc_length", 64'(run), 64'(elen));
        chk("wb_adr_hold", 64'(bus_if.wb_adr_o), 64'(x.adr));
      end
      prev_cyc = bus_if.wb_cyc_o;

      rb = 2'($urandom);
      if (bus_if.resp_v_o != 2'b00) begin
        if (!in_resp) begin
          if (expq.size() == 0) begin
            fail("unexpected_resp");
          end else begin
            e = expq.pop_front();
            chk("resp_v_idx", 64'(bus_if.resp_v_o), 64'(2'b01 << e.idx));
            chk("resp_data", bus_if.resp_data_o, e.data);
            chk("resp_err", 64'(bus_if.resp_err_o), 64'(e.err));
          end
          held_v = bus_if.resp_v_o;
          held_d = bus_if.resp_data_o;
          held_e = bus_if.resp_err_o;
          w = (bp_next >= 0) ? bp_next : int'($urandom % 4);
          in_resp = 1'b1;
        end else begin
          chk("resp_v_stable", 64'(bus_if.resp_v_o), 64'(held_v));
          chk("resp_data_stable", bus_if.resp_data_o, held_d);
          chk("resp_err_stable", 64'(bus_if.resp_err_o), 64'(held_e));
        end
        if (w == 0) begin
          bus_if.resp_ready_i = held_v | (rb & ~held_v);
          hs_pending = 1'b1;
          in_resp = 1'b0;
        end else begin
          bus_if.resp_ready_i = rb & ~held_v;
          w--;
        end
      end else begin
        if (in_resp) begin
          fail("resp_dropped");
          in_resp = 1'b0;
        end
        bus_if.resp_ready_i = rb;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    bus_if.req_v_i = 2'b00;
    bus_if.req_addr_i = '0;
    bus_if.req_data_i = '0;
    bus_if.req_sel_i = '0;
    bus_if.req_we_i = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus_if.req_ready_o), 64'd0);
    chk("rst_resp_v", 64'(bus_if.resp_v_o), 64'd0);
    chk("rst_cyc_stb_we", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o}), 64'd0);
    chk("rst_busy", 64'(bus_if.busy_o), 64'd0);
    chk("rst_resp_payload", 64'({bus_if.resp_err_o, bus_if.resp_data_o[62:0]}), 64'd0);
    chk("rst_wb_payload", 64'({bus_if.wb_adr_o, bus_if.wb_sel_o}), 64'd0);
    chk("rst_wb_dat", bus_if.wb_dat_o, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both requesters held for four grants: must alternate starting with 0.
    rand_req(0);
    rand_req(1);
    for (int k = 0; k < 4; k++) begin
      if (!pv[0]) rand_req(0);
      if (!pv[1]) rand_req(1);
      wait_grant(g);
      chk("contention_order", 64'(g), 64'(k % 2));
    end
    while (pv != 2'b00) wait_grant(g);
    wait_idle();

    // Single read with a 3-cycle target delay.
    set_req(0, 37'h100, 64'h0, 8'hFF, 1'b0, 0, 3, 64'hDEAD_BEEF, 1'b0);
    wait_grant(g);
    wait_idle();

    // Write from requester 1 answered with ack and err together.
    set_req(1, 37'h2A0, 64'h1234_5678_9ABC_DEF0, 8'h0F, 1'b1, 2, 2, 64'h0, 1'b0);
    wait_grant(g);
    wait_idle();

    // Silent target aborts after TO cycles; the next request is normal.
    set_req(0, 37'h300, 64'h0, 8'hFF, 1'b0, 3, 0, 64'h0, 1'b0);
    wait_grant(g);
    wait_idle();
    set_req(1, 37'h308, 64'h0, 8'hFF, 1'b0, 0, 1, 64'hCAFE_F00D_0000_0001, 1'b0);
    wait_grant(g);
    wait_idle();

    // Response held off for five cycles.
    bp_next = 5;
    set_req(0, 37'h400, 64'h0, 8'hFF, 1'b0, 0, 0, 64'h5555_AAAA_5555_AAAA, 1'b0);
    wait_grant(g);
    wait_idle();
    bp_next = -1;

    for (int n = 0; n < 60; n++) begin
      if (pv == 2'b00) rand_req(int'($urandom % 2));
      for (int j = 0; j < 2; j++) begin
        if (!pv[j] && ($urandom % 2 == 1)) rand_req(j);
      end
      wait_grant(g);
    end
    while (pv != 2'b00) wait_grant(g);
    wait_idle();

    // Reset in the middle of a bus cycle drops the transaction.
    set_req(0, 37'h500, 64'h0, 8'hFF, 1'b0, 3, 0, 64'h0, 1'b1);
    wait_grant(g);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midbus_rst_cyc_stb", 64'({bus_if.wb_cyc_o, bus_if.wb_stb_o}), 64'd0);
    chk("midbus_rst_busy", 64'(bus_if.busy_o), 64'd0);
    chk("midbus_rst_resp_v", 64'(bus_if.resp_v_o), 64'd0);
    in_flight = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'({bus_if.resp_v_o, bus_if.busy_o}), 64'd0);
    end
    @(posedge clk);
    #1;
    rand_req(0);
    rand_req(1);
    wait_grant(g);
    chk("post_rst_first_tie", 64'(g), 64'd0);
    wait_grant(g);
    wait_idle();

    chk("queues_empty", 64'(expq.size() + wbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
